pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Parametrised program-counter generator; successor to the single-width free-running PC register.
- Sits at the head of the fetch stage and drives the fetch address to instruction memory.
- Adds a configurable width, reset vector and instruction step, a valid/ready fetch handshake, stall, branch redirect, trap redirect, halt and misalignment flagging.

Parameters:
- XLEN, 32, PC width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value loaded by reset (XLEN bits).
- INST_BYTES, 4, PC increment and target alignment; power of two, 2 or 4.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall_i  in  1  pipeline stall; blocks PC advance.
- fetch_ready_i  in  1  fetch/memory accepts pc_o this cycle.
- redirect_valid_i  in  1  branch/jump redirect request.
- redirect_target_i  in  XLEN  branch/jump target.
- trap_valid_i  in  1  trap/exception redirect request.
- trap_vector_i  in  XLEN  trap handler address.
- halt_i  in  1  request to stop fetching.
- pc_o  out  XLEN  current fetch address.
- pc_valid_o  out  1  pc_o presented to fetch.
- ce_o  out  1  instruction memory chip enable.
- flush_o  out  1  one-cycle pulse: pc_o is a freshly redirected address.
- misalign_o  out  1  one-cycle pulse: the accepted target had nonzero low bits.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=BOOT; pc_o=RESET_VECTOR; ce_o=0, pc_valid_o=0, flush_o=0, misalign_o=0.
  - Reset asserted mid-operation forces these values immediately, with no clock needed.
- States: BOOT, RUN, HALT. ce_o=pc_valid_o=1 in RUN only.
- BOOT: first rising edge after rst deasserts -> RUN; pc_o stays RESET_VECTOR. Requests during BOOT are ignored.
- RUN, priority per edge:
  1. trap_valid_i: pc_o<=aligned(trap_vector_i); flush_o<=1. Ignores stall_i and fetch_ready_i.
  2. redirect_valid_i: pc_o<=aligned(redirect_target_i); flush_o<=1. Ignores stall_i and fetch_ready_i.
  3. halt_i: state<=HALT; pc_o held.
  4. Advance: fetch_ready_i && !stall_i -> pc_o<=pc_o+INST_BYTES.
  5. Otherwise: hold. pc_o must not change while pc_valid_o=1 && !fetch_ready_i unless a trap or redirect fires.
- HALT: ce_o=0, pc_valid_o=0, pc_o held.
  - trap_valid_i or redirect_valid_i loads the target, sets flush_o and returns to RUN, with the same priority as RUN.
  - halt_i alone keeps HALT. HALT with no halt_i and no redirect stays HALT; only a redirect or trap exits.
- aligned(x): x with its low log2(INST_BYTES) bits cleared.
- misalign_o<=1 in the same edge as a trap or redirect load whose target low bits are nonzero; otherwise 0.
- flush_o and misalign_o are registered and last exactly one cycle unless re-triggered on consecutive edges.
- Arithmetic: increment is modulo 2^XLEN. {XLEN{1'b1}} minus INST_BYTES-1 advances to 0 with no flag.
- Trap and redirect in the same cycle: trap wins, and the redirect is dropped (not queued).
- Halt and redirect in the same cycle: redirect wins, state stays RUN.
- Latency: one cycle from request to pc_o change. No combinational path from any input to any output.

Decomposition:
- Shared package holds:
  - state enum {BOOT, RUN, HALT};
  - ChipEnable/ChipDisable constants;
  - Zero constant;
  - XLEN default.
- No sub-module needed; the align function lives in the package.

Test Plan:
1. Reset release, fetch_ready_i=1, stall_i=0, RESET_VECTOR=0: cycle 1 after release shows ce_o=1, pc_o=0. Next edges give pc_o=4, 8, 12.
2. Backpressure: pc_o=0x10, fetch_ready_i=0 for 3 cycles -> pc_o stays 0x10 with pc_valid_o=1. Ready returns -> 0x14. Repeat with stall_i=1 -> same hold.
3. Redirect to 0x103 while stalled, INST_BYTES=4 -> next cycle pc_o=0x100, flush_o=1, misalign_o=1; the following cycle flush_o=0 and misalign_o=0.
4. trap_valid_i (vector 0x80) with redirect_valid_i (0x200) in the same cycle -> pc_o=0x80, flush_o=1; the redirect is never applied.
5. halt_i at pc_o=0x40 -> ce_o=0, pc_valid_o=0, pc_o=0x40 held for 5 cycles. Redirect to 0x300 -> RUN, pc_o=0x300, ce_o=1.
6. Wrap and reset: XLEN=32, redirect to 0xFFFF_FFFC, then advance -> pc_o=0. Assert rst mid-run -> pc_o=RESET_VECTOR and ce_o=0 without a clock edge.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared types, constants and the address-alignment helper for the fetch-stage PC generator.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;
    localparam logic Zero        = 1'b0;

    localparam int XlenDefault = 32;
    // Widest PC the helpers handle; callers widen into and truncate out of this.
    localparam int MaxXlen     = 64;

    function automatic logic [MaxXlen-1:0] align_addr(input logic [MaxXlen-1:0] addr,
                                                       input int                 inst_bytes);
        logic [MaxXlen-1:0] mask;
        mask = MaxXlen'(inst_bytes - 1);
        return addr & ~mask;
    endfunction

    function automatic logic is_misaligned(input logic [MaxXlen-1:0] addr,
                                           input int                 inst_bytes);
        logic [MaxXlen-1:0] mask;
        mask = MaxXlen'(inst_bytes - 1);
        return |(addr & mask);
    endfunction

endpackage

// File: rtl/pc_gen.sv
// Program-counter generator at the head of fetch: boot, sequential advance with
// backpressure/stall, trap and branch redirects, halt, and misalignment flagging.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              XLEN         = XlenDefault,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              INST_BYTES   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            fetch_ready_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_target_i,
    input  logic            trap_valid_i,
    input  logic [XLEN-1:0] trap_vector_i,
    input  logic            halt_i,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    output logic            ce_o,
    output logic            flush_o,
    output logic            misalign_o
);

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            flush_q, flush_d;
    logic            misalign_q, misalign_d;

    logic [XLEN-1:0] target;
    logic            load;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VECTOR;
            flush_q    <= Zero;
            misalign_q <= Zero;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            flush_q    <= flush_d;
            misalign_q <= misalign_d;
        end
    end

    // Trap outranks redirect; the losing redirect is simply dropped.
    always_comb begin
        load       = trap_valid_i || redirect_valid_i;
        target     = trap_valid_i ? trap_vector_i : redirect_target_i;
        state_d    = state_q;
        pc_d       = pc_q;
        flush_d    = Zero;
        misalign_d = Zero;
        unique case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN, HALT: begin
                if (load) begin
                    state_d    = RUN;
                    pc_d       = XLEN'(align_addr(MaxXlen'(target), INST_BYTES));
                    flush_d    = 1'b1;
                    misalign_d = is_misaligned(MaxXlen'(target), INST_BYTES);
                end else if (state_q == RUN) begin
                    if (halt_i) begin
                        state_d = HALT;
                    end else if (fetch_ready_i && !stall_i) begin
                        pc_d = pc_q + XLEN'(INST_BYTES);
                    end
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_comb begin
        pc_o       = pc_q;
        flush_o    = flush_q;
        misalign_o = misalign_q;
        ce_o       = ChipDisable;
        pc_valid_o = Zero;
        if (state_q == RUN) begin
            ce_o       = ChipEnable;
            pc_valid_o = 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: each scenario queues expected outputs as it drives
// a cycle and pops them once the registered outputs settle after the edge.
module tb_pc_gen;

    typedef struct packed {
        logic        stall;
        logic        ready;
        logic        rv;
        logic [31:0] rt;
        logic        tv;
        logic [31:0] tvec;
        logic        halt;
    } stim_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        valid;
        logic        ce;
        logic        flush;
        logic        mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_i = 1'b0;
    logic        fetch_ready_i = 1'b0;
    logic        redirect_valid_i = 1'b0;
    logic [31:0] redirect_target_i = '0;
    logic        trap_valid_i = 1'b0;
    logic [31:0] trap_vector_i = '0;
    logic        halt_i = 1'b0;
    logic [31:0] pc_o;
    logic        pc_valid_o;
    logic        ce_o;
    logic        flush_o;
    logic        misalign_o;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    pc_gen #(
        .XLEN        (32),
        .RESET_VECTOR(32'h0000_0000),
        .INST_BYTES  (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall_i          (stall_i),
        .fetch_ready_i    (fetch_ready_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_target_i(redirect_target_i),
        .trap_valid_i     (trap_valid_i),
        .trap_vector_i    (trap_vector_i),
        .halt_i           (halt_i),
        .pc_o             (pc_o),
        .pc_valid_o       (pc_valid_o),
        .ce_o             (ce_o),
        .flush_o          (flush_o),
        .misalign_o       (misalign_o)
    );

    always #5 clk = ~clk;

    function automatic stim_t S(logic stall, logic ready, logic rv, logic [31:0] rt,
                                logic tv, logic [31:0] tvec, logic halt);
        return '{stall, ready, rv, rt, tv, tvec, halt};
    endfunction

    function automatic exp_t E(logic [31:0] pc, logic valid, logic ce, logic flush, logic mis);
        return '{pc, valid, ce, flush, mis};
    endfunction

    task automatic drive(input stim_t s);
        stall_i           = s.stall;
        fetch_ready_i     = s.ready;
        redirect_valid_i  = s.rv;
        redirect_target_i = s.rt;
        trap_valid_i      = s.tv;
        trap_vector_i     = s.tvec;
        halt_i            = s.halt;
    endtask

    task automatic test_reset();
        exp_t e;
        e = E(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        checks++;
        if ({pc_o, pc_valid_o, ce_o, flush_o, misalign_o} !== e) begin
            errors++;
            $display("[TB] FAIL reset_initial got pc=%h v=%b ce=%b fl=%b mis=%b want pc=%h v=0 ce=0 fl=0 mis=0",
                     pc_o, pc_valid_o, ce_o, flush_o, misalign_o, e.pc);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if ({pc_o, pc_valid_o, ce_o, flush_o, misalign_o} !== e) begin
            errors++;
            $display("[TB] FAIL reset_held got pc=%h v=%b ce=%b fl=%b mis=%b want pc=%h v=0 ce=0 fl=0 mis=0",
                     pc_o, pc_valid_o, ce_o, flush_o, misalign_o, e.pc);
        end
        rst = 1'b1;
    endtask

    task automatic test_advance();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  e;
        st.push_back(S(0, 1, 0, 0, 0, 0, 0)); ex.push_back(E(32'h0, 1, 1, 0, 0));
        st.push_back(S(0, 1, 0, 0, 0, 0, 0)); ex.push_back(E(32'h4, 1, 1, 0, 0));
        st.push_back(S(0, 1, 0, 0, 0, 0, 0)); ex.push_back(E(32'h8, 1, 1, 0, 0));
        st.push_back(S(0, 1, 0, 0, 0, 0, 0)); ex.push_back(E(32'hC, 1, 1, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]);
            sb.push_back(ex[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if ({pc_o, pc_valid_o, ce_o, flush_o, misalign_o} !== e) begin
                errors++;
                $display("[TB] FAIL advance[%0d] got pc=%h v=%b ce=%b fl=%b mis=%b want pc=%h v=%b ce=%b fl=%b mis=%b",
                         i, pc_o, pc_valid_o, ce_o, flush_o, misalign_o, e.pc, e.valid, e.ce, e.flush, e.mis);
            end
        end
    endtask

    task automatic test_backpressure();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  e;
        st.push_back(S(0, 1, 0, 0, 0, 0, 0)); ex.push_back(E(32'h10, 1, 1, 0, 0));
        for (int k = 0; k < 3; k++) begin
            st.push_back(S(0, 0, 0, 0, 0, 0, 0)); ex.push_back(E(32'h10, 1, 1, 0, 0));
        end
        st.push_back(S(0, 1, 0, 0, 0, 0, 0)); ex.push_back(E(32'h14, 1, 1, 0, 0));
        for (int k = 0; k < 3; k++) begin
            st.push_back(S(1, 1, 0, 0, 0, 0, 0)); ex.push_back(E(32'h14, 1, 1, 0, 0));
        end
        st.push_back(S(0, 1, 0, 0, 0, 0, 0)); ex.push_back(E(32'h18, 1, 1, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]);
            sb.push_back(ex[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if ({pc_o, pc_valid_o, ce_o, flush_o, misalign_o} !== e) begin
                errors++;
                $display("[TB] FAIL backpressure[%0d] got pc=%h v=%b ce=%b fl=%b mis=%b want pc=%h v=%b ce=%b fl=%b mis=%b",
                         i, pc_o, pc_valid_o, ce_o, flush_o, misalign_o, e.pc, e.valid, e.ce, e.flush, e.mis);
            end
        end
    endtask

    task automatic test_redirect_misalign();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  e;
        st.push_back(S(1, 1, 1, 32'h103, 0, 0, 0)); ex.push_back(E(32'h100, 1, 1, 1, 1));
        st.push_back(S(1, 1, 0, 0, 0, 0, 0));       ex.push_back(E(32'h100, 1, 1, 0, 0));
        st.push_back(S(0, 1, 0, 0, 0, 0, 0));       ex.push_back(E(32'h104, 1, 1, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]);
            sb.push_back(ex[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if ({pc_o, pc_valid_o, ce_o, flush_o, misalign_o} !== e) begin
                errors++;
                $display("[TB] FAIL redirect[%0d] got pc=%h v=%b ce=%b fl=%b mis=%b want pc=%h v=%b ce=%b fl=%b mis=%b",
                         i, pc_o, pc_valid_o, ce_o, flush_o, misalign_o, e.pc, e.valid, e.ce, e.flush, e.mis);
            end
        end
    endtask

    task automatic test_trap_priority();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  e;
        st.push_back(S(0, 1, 1, 32'h200, 1, 32'h80, 0)); ex.push_back(E(32'h80, 1, 1, 1, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0));             ex.push_back(E(32'h80, 1, 1, 0, 0));
        st.push_back(S(0, 1, 0, 0, 0, 0, 0));             ex.push_back(E(32'h84, 1, 1, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]);
            sb.push_back(ex[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if ({pc_o, pc_valid_o, ce_o, flush_o, misalign_o} !== e) begin
                errors++;
                $display("[TB] FAIL trap_priority[%0d] got pc=%h v=%b ce=%b fl=%b mis=%b want pc=%h v=%b ce=%b fl=%b mis=%b",
                         i, pc_o, pc_valid_o, ce_o, flush_o, misalign_o, e.pc, e.valid, e.ce, e.flush, e.mis);
            end
        end
    endtask

    task automatic test_halt();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  e;
        st.push_back(S(0, 1, 1, 32'h40, 0, 0, 0)); ex.push_back(E(32'h40, 1, 1, 1, 0));
        st.push_back(S(0, 1, 0, 0, 0, 0, 1));      ex.push_back(E(32'h40, 0, 0, 0, 0));
        for (int k = 0; k < 5; k++) begin
            st.push_back(S(0, 1, 0, 0, 0, 0, 0));  ex.push_back(E(32'h40, 0, 0, 0, 0));
        end
        st.push_back(S(0, 1, 1, 32'h300, 0, 0, 0)); ex.push_back(E(32'h300, 1, 1, 1, 0));
        st.push_back(S(0, 1, 0, 0, 0, 0, 0));       ex.push_back(E(32'h304, 1, 1, 0, 0));
        st.push_back(S(0, 1, 1, 32'h500, 0, 0, 1)); ex.push_back(E(32'h500, 1, 1, 1, 0));
        st.push_back(S(0, 1, 0, 0, 0, 0, 0));       ex.push_back(E(32'h504, 1, 1, 0, 0));
        st.push_back(S(0, 1, 0, 0, 0, 0, 1));       ex.push_back(E(32'h504, 0, 0, 0, 0));
        st.push_back(S(0, 1, 0, 0, 1, 32'h122, 1)); ex.push_back(E(32'h120, 1, 1, 1, 1));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0));       ex.push_back(E(32'h120, 1, 1, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]);
            sb.push_back(ex[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if ({pc_o, pc_valid_o, ce_o, flush_o, misalign_o} !== e) begin
                errors++;
                $display("[TB] FAIL halt[%0d] got pc=%h v=%b ce=%b fl=%b mis=%b want pc=%h v=%b ce=%b fl=%b mis=%b",
                         i, pc_o, pc_valid_o, ce_o, flush_o, misalign_o, e.pc, e.valid, e.ce, e.flush, e.mis);
            end
        end
    endtask

    task automatic test_wrap_and_async_reset();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  e;
        st.push_back(S(0, 1, 1, 32'hFFFF_FFFC, 0, 0, 0)); ex.push_back(E(32'hFFFF_FFFC, 1, 1, 1, 0));
        st.push_back(S(0, 1, 0, 0, 0, 0, 0));             ex.push_back(E(32'h0, 1, 1, 0, 0));
        st.push_back(S(0, 1, 0, 0, 0, 0, 0));             ex.push_back(E(32'h4, 1, 1, 0, 0));
        st.push_back(S(0, 1, 1, 32'h202, 0, 0, 0));       ex.push_back(E(32'h200, 1, 1, 1, 1));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]);
            sb.push_back(ex[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if ({pc_o, pc_valid_o, ce_o, flush_o, misalign_o} !== e) begin
                errors++;
                $display("[TB] FAIL wrap[%0d] got pc=%h v=%b ce=%b fl=%b mis=%b want pc=%h v=%b ce=%b fl=%b mis=%b",
                         i, pc_o, pc_valid_o, ce_o, flush_o, misalign_o, e.pc, e.valid, e.ce, e.flush, e.mis);
            end
        end
        #2;
        rst = 1'b0;
        #1;
        e = E(32'h0, 0, 0, 0, 0);
        checks++;
        if ({pc_o, pc_valid_o, ce_o, flush_o, misalign_o} !== e) begin
            errors++;
            $display("[TB] FAIL async_reset got pc=%h v=%b ce=%b fl=%b mis=%b want pc=%h v=0 ce=0 fl=0 mis=0",
                     pc_o, pc_valid_o, ce_o, flush_o, misalign_o, e.pc);
        end
    endtask

    task automatic test_boot_ignores_requests();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  e;
        drive(S(0, 1, 1, 32'h200, 1, 32'h80, 0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        st.push_back(S(0, 1, 1, 32'h200, 1, 32'h80, 0)); ex.push_back(E(32'h0, 1, 1, 0, 0));
        st.push_back(S(0, 1, 1, 32'h200, 1, 32'h80, 0)); ex.push_back(E(32'h80, 1, 1, 1, 0));
        st.push_back(S(0, 1, 0, 0, 0, 0, 0));             ex.push_back(E(32'h84, 1, 1, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]);
            sb.push_back(ex[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if ({pc_o, pc_valid_o, ce_o, flush_o, misalign_o} !== e) begin
                errors++;
                $display("[TB] FAIL boot[%0d] got pc=%h v=%b ce=%b fl=%b mis=%b want pc=%h v=%b ce=%b fl=%b mis=%b",
                         i, pc_o, pc_valid_o, ce_o, flush_o, misalign_o, e.pc, e.valid, e.ce, e.flush, e.mis);
            end
        end
    endtask

    initial begin
        test_reset();
        test_advance();
        test_backpressure();
        test_redirect_misalign();
        test_trap_priority();
        test_halt();
        test_wrap_and_async_reset();
        test_boot_ignores_requests();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
